// File: rtl/fir_decim_out.sv
// Decimating output stage for the 4-tap FIR: picks (or averages, with FIR_DECIM_AVG_EN)
// one sample per DECIM and queues it in a show-ahead FIFO with sticky overflow.
module fir_decim_out #(
  parameter int DECIM = 4,
  parameter int DEPTH = 4
) (
  input  logic                      system1000,
  input  logic                      system1000_rst,
  input  logic signed [15:0]        x_t,
  input  logic                      x_valid,
  output logic signed [15:0]        dec_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  input  logic                      ovf_clr
);
  localparam int LG = $clog2(DECIM);
  localparam int PW = (LG > 0) ? LG : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [PW-1:0]        ph_q, ph_d;
  logic                 emit;
  logic signed [15:0]   din;

  assign emit = x_valid && (ph_q == PW'(DECIM - 1));

  always_comb begin
    ph_d = ph_q;
    if (x_valid) ph_d = emit ? '0 : ph_q + PW'(1);
  end

`ifdef FIR_DECIM_AVG_EN
  localparam int ACCW = 16 + LG;
  logic signed [ACCW-1:0] acc_q, acc_d, xe, sum, shv;

  assign xe  = ACCW'(x_t);
  assign sum = acc_q + xe;
  assign shv = sum >>> LG;
  assign din = shv[15:0];

  always_comb begin
    acc_d = acc_q;
    if (x_valid) acc_d = emit ? '0 : sum;
  end

  always_ff @(posedge system1000 or posedge system1000_rst)
    if (system1000_rst) acc_q <= '0;
    else                acc_q <= acc_d;
`else
  assign din = x_t;
`endif

  logic signed [15:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d, rd_inc;
  logic [LW-1:0]      level_q, level_d;
  logic signed [15:0] dout_q, dout_d;
  logic               ovf_q, ovf_d;
  logic               full, empty, pop, push, drop;

  assign full   = (level_q == LW'(DEPTH));
  assign empty  = (level_q == '0);
  assign pop    = !empty && out_ready;
  assign push   = emit && (!full || pop);
  assign drop   = emit && full && !pop;
  assign rd_inc = rd_q + AW'(1);

  always_comb begin
    wr_d    = push ? wr_q + AW'(1) : wr_q;
    rd_d    = pop ? rd_inc : rd_q;
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
    // dout_q tracks the head after this edge; it holds once the FIFO drains
    dout_d = dout_q;
    if (pop) begin
      if (level_q > LW'(1)) dout_d = mem_q[rd_inc];
      else if (push)        dout_d = din;
    end else if (push && empty) begin
      dout_d = din;
    end
    ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge system1000 or posedge system1000_rst)
    if (system1000_rst) begin
      ph_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ph_q    <= ph_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
    end

  always_ff @(posedge system1000)
    if (push) mem_q[wr_q] <= din;

  assign dec_out   = dout_q;
  assign out_valid = !empty;
  assign level     = level_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_fir_decim_out.sv
// Randomized and directed bench for fir_decim_out against a queue-based reference model.
module tb_fir_decim_out;
  localparam int DECIM = 4;
  localparam int DEPTH = 4;
`ifdef FIR_DECIM_AVG_EN
  localparam int OFS = 2;
`else
  localparam int OFS = 0;
`endif

  logic clk = 0, rst = 1;
  logic signed [15:0] x = 0;
  logic xv = 0, rdy = 0, clr = 0;
  logic signed [15:0] dec_out;
  logic out_valid, overflow;
  logic [$clog2(DEPTH):0] level;

  fir_decim_out #(.DECIM(DECIM), .DEPTH(DEPTH)) dut (
    .system1000(clk), .system1000_rst(rst), .x_t(x), .x_valid(xv),
    .dec_out(dec_out), .out_valid(out_valid), .out_ready(rdy),
    .level(level), .overflow(overflow), .ovf_clr(clr));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int q[$], grp[$];
  bit m_ovf = 0;
  int m_last = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic int grp_value();
    int s = 0, v;
`ifdef FIR_DECIM_AVG_EN
    foreach (grp[i]) s += grp[i];
    v = s / DECIM;
    if ((s % DECIM) != 0 && s < 0) v -= 1;
`else
    s = 0;
    v = grp[grp.size()-1];
`endif
    return v;
  endfunction

  function automatic void m_reset();
    q.delete(); grp.delete(); m_ovf = 0; m_last = 0;
  endfunction

  function automatic void m_step(input bit v, input int xi, input bit r, input bit c);
    bit pop = (q.size() > 0) && r;
    bit emit = 0, drop = 0;
    int val = 0;
    if (v) begin
      grp.push_back(xi);
      if (grp.size() == DECIM) begin emit = 1; val = grp_value(); grp.delete(); end
    end
    if (pop) void'(q.pop_front());
    if (emit) begin
      if (q.size() < DEPTH) q.push_back(val);
      else drop = 1;
    end
    m_ovf = drop ? 1'b1 : (c ? 1'b0 : m_ovf);
    if (q.size() > 0) m_last = q[0];
  endfunction

  task automatic cyc(input bit v, input int xi, input bit r, input bit c);
    xv = v; x = 16'(xi); rdy = r; clr = c;
    m_step(v, xi, r, c);
    @(posedge clk); #1;
    chk("level", int'(level), q.size());
    chk("out_valid", int'(out_valid), int'(q.size() > 0));
    chk("dec_out", int'(dec_out), m_last);
    chk("overflow", int'(overflow), int'(m_ovf));
  endtask

  task automatic drain(input int first, input int n);
    for (int k = 0; k < n; k++) begin
      chk("drain_val", int'(dec_out), first + 4*k);
      cyc(0, 0, 1, 0);
    end
  endtask

  task automatic fill(input int n);
    for (int i = 1; i <= n; i++) cyc(1, i, 0, 0);
  endtask

  initial begin
    logic signed [15:0] r16;
    m_reset();
    repeat (2) @(posedge clk); #1;
    chk("rst_level", int'(level), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_dout", int'(dec_out), 0);
    chk("rst_ovf", int'(overflow), 0);
    rst = 0;

    for (int i = 1; i <= 12; i++) cyc(1, i, 1, 0);
    for (int i = 1; i <= 12; i++) begin cyc(1, i, 1, 0); cyc(0, 99, 1, 0); end

    fill(20);
    chk("ovf_level", int'(level), 4);
    chk("ovf_set", int'(overflow), 1);
    drain(4 - OFS, 4);
    cyc(0, 0, 0, 1);
    chk("ovf_clr", int'(overflow), 0);

    fill(19);
    cyc(1, 20, 1, 0);
    chk("fullpop_level", int'(level), 4);
    chk("fullpop_ovf", int'(overflow), 0);
    drain(8 - OFS, 4);

    fill(19);
    cyc(1, 20, 0, 1);
    chk("collide_ovf", int'(overflow), 1);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 1);

    fill(10);
    @(negedge clk);
    rst = 1; #1;
    m_reset();
    chk("arst_level", int'(level), 0);
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_dout", int'(dec_out), 0);
    chk("arst_ovf", int'(overflow), 0);
    @(posedge clk); #1; rst = 0;
    for (int i = 1; i <= 3; i++) cyc(1, i, 0, 0);
    chk("rel_no_emit", int'(level), 0);
    cyc(1, 4, 0, 0);
    chk("rel_emit4", int'(level), 1);
    cyc(0, 0, 1, 0);

`ifdef FIR_DECIM_AVG_EN
    cyc(1, -3, 0, 0); cyc(1, -2, 0, 0); cyc(1, 5, 0, 0); cyc(1, 7, 0, 0);
    chk("avg_pos", int'(dec_out), 1);
    cyc(0, 0, 1, 0);
    cyc(1, -1, 0, 0); cyc(1, -1, 0, 0); cyc(1, -1, 0, 0); cyc(1, -2, 0, 0);
    chk("avg_neg", int'(dec_out), -2);
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 32767, 0, 0);
    chk("avg_max", int'(dec_out), 32767);
    cyc(0, 0, 1, 0);
`endif

    for (int n = 0; n < 1500; n++) begin
      r16 = 16'($urandom);
      cyc(($urandom_range(9) < 7), int'(r16), $urandom_range(1), ($urandom_range(19) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
